// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - XGMII control characters, Ethernet length limits, CRC32 constants, pktgen FSM encoding
package xgmii_pkg;

  localparam logic [7:0]  XGMII_IDLE  = 8'h07;
  localparam logic [7:0]  XGMII_START = 8'hfb;
  localparam logic [7:0]  XGMII_TERM  = 8'hfd;
  localparam logic [7:0]  XGMII_ERROR = 8'hfe;

  localparam logic [63:0] PREAMBLE_WORD = {56'hd5555555555555, XGMII_START};
  localparam logic [71:0] SFD_WORD      = {8'h01, PREAMBLE_WORD};
  localparam logic [71:0] IDLE_WORD     = {8'hff, {8{XGMII_IDLE}}};

  localparam logic [10:0] ETH_MIN_LEN = 11'd64;
  localparam logic [10:0] ETH_MAX_LEN = 11'd1518;

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = {<<{CRC32_POLY}};
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_TERM,
    ST_IFG
  } pktgen_state_t;

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (len < ETH_MIN_LEN)      return ETH_MIN_LEN;
    else if (len > ETH_MAX_LEN) return ETH_MAX_LEN;
    else                        return len;
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// rtl/crc32_d64.sv - combinational reflected CRC32 step over up to 8 bytes (lanes contiguous from lane 0)
module crc32_d64
  import xgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [7:0]  byte_en,
  output logic [31:0] crc_out
);

  logic [31:0] acc;

  // Lane 0 is first on the wire, and each byte is consumed LSB first.
  always_comb begin
    acc = crc_in;
    for (int lane = 0; lane < 8; lane++) begin
      if (byte_en[lane]) begin
        for (int b = 0; b < 8; b++) begin
          if (acc[0] ^ data[8*lane+b]) acc = (acc >> 1) ^ CRC32_POLY_REFL;
          else                         acc = acc >> 1;
        end
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/xgmii_pktgen.sv
// rtl/xgmii_pktgen.sv - XGMII TX frame generator driving {txc,txd} with DA/SA/EtherType/pattern/FCS
// Define XGMII_PKTGEN_SEQ_EN to carry a 32-bit per-frame sequence number in payload bytes 14-17.
module xgmii_pktgen
  import xgmii_pkg::*;
#(
  parameter logic [3:0]  IFG_CYCLES = 4'h2,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
  input  logic        xgmii_tx_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic [10:0] frame_len,
  input  logic [15:0] frame_cnt,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  output logic [71:0] xgmii_txd,
  output logic        busy,
  output logic [31:0] tx_frames
);

  pktgen_state_t state, state_nxt;
  logic [10:0]  len_l, data_end;
  logic [15:0]  cnt_l, sent, sent_now;
  logic [95:0]  mac_l;
  logic [111:0] hdr;
  logic [7:0]   wcnt, last_word;
  logic [3:0]   ifg_cnt;
  logic [31:0]  crc, crc_nxt, fcs;
  logic         stop_seen, burst_done;
  logic [10:0]  lane_k [8];
  logic [7:0]   pay_off;
  logic [1:0]   fcs_idx;
  logic [63:0]  word_data;
  logic [7:0]   data_be;
  logic [71:0]  word_out;
`ifdef XGMII_PKTGEN_SEQ_EN
  logic [31:0]  seq_num;
`endif

  assign hdr       = {mac_l, ETHERTYPE};
  assign data_end  = len_l - 11'd4;
  assign last_word = len_l[10:3];
  assign fcs       = ~crc_nxt;
  assign sent_now  = (state == ST_TERM) ? sent + 16'd1 : sent;
  assign burst_done = stop_seen || stop || (cnt_l != 16'd0 && sent_now == cnt_l);

  always_comb begin
    for (int lane = 0; lane < 8; lane++) lane_k[lane] = {wcnt, 3'b000} + 11'(lane);
  end

  // Raw frame bytes for the current word; lanes past the CRC-covered region are masked off.
  always_comb begin
    word_data = '0;
    data_be   = '0;
    pay_off   = '0;
    for (int lane = 0; lane < 8; lane++) begin
      pay_off = lane_k[lane][7:0] - 8'd14;
      data_be[lane] = (lane_k[lane] < data_end);
      if (lane_k[lane] < 11'd14)
        word_data[8*lane +: 8] = 8'(hdr >> (7'd104 - {lane_k[lane][3:0], 3'b000}));
`ifdef XGMII_PKTGEN_SEQ_EN
      else if (lane_k[lane] < 11'd18)
        word_data[8*lane +: 8] = 8'(seq_num >> (5'd24 - {pay_off[1:0], 3'b000}));
`endif
      else
        word_data[8*lane +: 8] = pay_off;
    end
  end

  crc32_d64 u_crc (
    .crc_in  (crc),
    .data    (word_data),
    .byte_en (data_be),
    .crc_out (crc_nxt)
  );

  // FCS may straddle two words; the second word has no data lanes so crc_nxt == crc there.
  always_comb begin
    word_out = IDLE_WORD;
    fcs_idx  = '0;
    for (int lane = 0; lane < 8; lane++) begin
      fcs_idx = lane_k[lane][1:0] - data_end[1:0];
      if (lane_k[lane] < data_end) begin
        word_out[64+lane]      = 1'b0;
        word_out[8*lane +: 8]  = word_data[8*lane +: 8];
      end else if (lane_k[lane] < len_l) begin
        word_out[64+lane]      = 1'b0;
        word_out[8*lane +: 8]  = 8'(fcs >> {fcs_idx, 3'b000});
      end else if (lane_k[lane] == len_l) begin
        word_out[8*lane +: 8]  = XGMII_TERM;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PRE;
      ST_PRE:  state_nxt = ST_DATA;
      ST_DATA: if (wcnt == last_word - 8'd1) state_nxt = ST_TERM;
      ST_TERM: begin
        if (IFG_CYCLES != 4'd0) state_nxt = ST_IFG;
        else                    state_nxt = burst_done ? ST_IDLE : ST_PRE;
      end
      ST_IFG:  if (ifg_cnt == IFG_CYCLES - 4'd1) state_nxt = burst_done ? ST_IDLE : ST_PRE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge xgmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      xgmii_txd <= IDLE_WORD;
      busy      <= 1'b0;
      tx_frames <= '0;
      len_l     <= ETH_MIN_LEN;
      cnt_l     <= '0;
      mac_l     <= '0;
      sent      <= '0;
      wcnt      <= '0;
      ifg_cnt   <= '0;
      crc       <= CRC32_INIT;
      stop_seen <= 1'b0;
`ifdef XGMII_PKTGEN_SEQ_EN
      seq_num   <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        ST_PRE:           xgmii_txd <= SFD_WORD;
        ST_DATA, ST_TERM: xgmii_txd <= word_out;
        default:          xgmii_txd <= IDLE_WORD;
      endcase

      if (state != ST_IDLE && stop) stop_seen <= 1'b1;
      if (state == ST_IDLE && start) begin
        len_l <= clamp_len(frame_len);
        cnt_l <= frame_cnt;
        mac_l <= {dst_mac, src_mac};
        sent  <= '0;
        busy  <= 1'b1;
      end

      if (state == ST_PRE) begin
        wcnt <= '0;
        crc  <= CRC32_INIT;
      end else if (state == ST_DATA || state == ST_TERM) begin
        wcnt <= wcnt + 8'd1;
        crc  <= crc_nxt;
      end

      ifg_cnt <= (state == ST_IFG) ? ifg_cnt + 4'd1 : 4'd0;

      if (state == ST_TERM) begin
        tx_frames <= tx_frames + 32'd1;
        sent      <= sent + 16'd1;
`ifdef XGMII_PKTGEN_SEQ_EN
        seq_num   <= seq_num + 32'd1;
`endif
      end

      if (state != ST_IDLE && state_nxt == ST_IDLE) begin
        busy      <= 1'b0;
        stop_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xgmii_pktgen.sv
// tb/tb_xgmii_pktgen.sv - scoreboard bench for xgmii_pktgen with a byte-stream reference model
module tb_xgmii_pktgen;

  localparam logic [71:0] IDLE_W = {8'hff, 64'h0707070707070707};
  localparam logic [71:0] SFD_W  = {8'h01, 64'hd5555555555555fb};

  logic        xgmii_tx_clk = 1'b0;
  logic        sys_rst, start, stop;
  logic [10:0] frame_len;
  logic [15:0] frame_cnt;
  logic [47:0] dst_mac, src_mac;
  logic [71:0] xgmii_txd;
  logic        busy;
  logic [31:0] tx_frames;

  typedef struct {
    logic [71:0] w;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_pass = 0;
  int   exp_frames = 0, frames_seen = 0, busy_falls = 0, gap = 0;
  bit   gap_active = 0, busy_prev = 0;
`ifdef XGMII_PKTGEN_SEQ_EN
  logic [31:0] exp_seq = 0;
`endif

  xgmii_pktgen dut (
    .xgmii_tx_clk (xgmii_tx_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .stop         (stop),
    .frame_len    (frame_len),
    .frame_cnt    (frame_cnt),
    .dst_mac      (dst_mac),
    .src_mac      (src_mac),
    .xgmii_txd    (xgmii_txd),
    .busy         (busy),
    .tx_frames    (tx_frames)
  );

  always #5 xgmii_tx_clk = ~xgmii_tx_clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  // Reference: build the frame as a byte list, then serialise onto the wire 8 bytes per word.
  task automatic push_frame(input int len_in, input logic [47:0] da, input logic [47:0] sa);
    int L;
    logic [7:0]  fb[$];
    logic [8:0]  ws[$];
    logic [31:0] c;
    exp_t        e;
    L = (len_in < 64) ? 64 : (len_in > 1518) ? 1518 : len_in;
    for (int i = 0; i < 6; i++) fb.push_back(8'(da >> (40 - 8*i)));
    for (int i = 0; i < 6; i++) fb.push_back(8'(sa >> (40 - 8*i)));
    fb.push_back(8'h88);
    fb.push_back(8'hb5);
    for (int k = 14; k < L - 4; k++) fb.push_back(8'(k - 14));
`ifdef XGMII_PKTGEN_SEQ_EN
    for (int i = 0; i < 4; i++) fb[14+i] = 8'(exp_seq >> (24 - 8*i));
    exp_seq++;
`endif
    c = 32'hffffffff;
    foreach (fb[i]) begin
      c ^= {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fb.push_back(8'(c >> (8*i)));
    e.w = SFD_W;
    e.last = 0;
    exp_q.push_back(e);
    foreach (fb[i]) ws.push_back({1'b0, fb[i]});
    ws.push_back({1'b1, 8'hfd});
    while (ws.size() % 8 != 0) ws.push_back({1'b1, 8'h07});
    for (int w = 0; w < ws.size() / 8; w++) begin
      for (int l = 0; l < 8; l++) begin
        e.w[64+l]    = ws[8*w+l][8];
        e.w[8*l +: 8] = ws[8*w+l][7:0];
      end
      e.last = (w == ws.size() / 8 - 1);
      exp_q.push_back(e);
    end
    exp_frames++;
  endtask

  always @(negedge xgmii_tx_clk) begin
    if (sys_rst) begin
      gap_active = 0;
      busy_prev  = 0;
    end else begin
      if (busy_prev && !busy) busy_falls++;
      busy_prev = busy;
      if (xgmii_txd !== IDLE_W) begin
        if (xgmii_txd === SFD_W && gap_active) begin
          chk("ifg_gap", 72'(gap), 72'd2);
          gap_active = 0;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_word", xgmii_txd, IDLE_W);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wire_word", xgmii_txd, e.w);
          if (e.last) begin
            gap_active = 1;
            gap = 0;
            frames_seen++;
          end
        end
      end else if (gap_active) begin
        if (!busy) gap_active = 0;
        else gap++;
      end
    end
  end

  task automatic start_burst(input int len, input int cnt, input logic [47:0] da, input logic [47:0] sa);
    @(posedge xgmii_tx_clk); #1;
    frame_len = 11'(len);
    frame_cnt = 16'(cnt);
    dst_mac   = da;
    src_mac   = sa;
    start     = 1;
    @(posedge xgmii_tx_clk); #1;
    start = 0;
    @(posedge xgmii_tx_clk); #1;
    chk("sfd_latency", xgmii_txd, SFD_W);
  endtask

  task automatic finish_burst(input int budget);
    int cyc = 0;
    while (busy && cyc < budget) begin
      @(posedge xgmii_tx_clk); #1;
      cyc++;
    end
    chk("idle_timeout", 72'(busy), 72'd0);
    repeat (3) @(posedge xgmii_tx_clk);
    #1;
    chk("queue_drained", 72'(exp_q.size()), 72'd0);
    chk("tx_frames", 72'(tx_frames), 72'(exp_frames));
  endtask

  function automatic logic [47:0] rand_mac();
    return {16'($urandom), $urandom};
  endfunction

  initial begin
    int lens[5] = '{65, 20, 2000, 72, 1517};
    int f0, b0, len, cyc;
    logic [47:0] da, sa;
    sys_rst = 1; start = 0; stop = 0;
    frame_len = '0; frame_cnt = '0; dst_mac = '0; src_mac = '0;
    repeat (3) @(posedge xgmii_tx_clk);
    #1;
    chk("rst_txd", xgmii_txd, IDLE_W);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_tx_frames", 72'(tx_frames), 72'd0);
    sys_rst = 0;

    push_frame(64, 48'hffffffffffff, 48'h001122334455);
    start_burst(64, 1, 48'hffffffffffff, 48'h001122334455);
    @(posedge xgmii_tx_clk); #1;
    chk("first_data_word", xgmii_txd, {8'h00, 64'h1100ffffffffffff});
    finish_burst(300);
    chk("busy_falls_single", 72'(busy_falls), 72'd1);

    foreach (lens[i]) begin
      da = rand_mac(); sa = rand_mac();
      push_frame(lens[i], da, sa);
      start_burst(lens[i], 1, da, sa);
      finish_burst(400);
    end

    b0 = busy_falls;
    len = $urandom_range(64, 300);
    da = rand_mac(); sa = rand_mac();
    for (int i = 0; i < 3; i++) push_frame(len, da, sa);
    start_burst(len, 3, da, sa);
    repeat (20) @(posedge xgmii_tx_clk);
    #1; start = 1; frame_len = 11'd100;
    @(posedge xgmii_tx_clk); #1; start = 0;
    finish_burst(2000);
    chk("busy_falls_burst", 72'(busy_falls - b0), 72'd1);

    f0 = frames_seen;
    len = $urandom_range(64, 150);
    da = rand_mac(); sa = rand_mac();
    for (int i = 0; i < 5; i++) push_frame(len, da, sa);
    start_burst(len, 0, da, sa);
    cyc = 0;
    while (frames_seen < f0 + 4 && cyc < 2000) begin
      @(posedge xgmii_tx_clk);
      cyc++;
    end
    chk("stop_wait", 72'(frames_seen - f0), 72'd4);
    repeat (6) @(posedge xgmii_tx_clk);
    #1; stop = 1;
    @(posedge xgmii_tx_clk); #1; stop = 0;
    finish_burst(1000);
    chk("stop_frames", 72'(frames_seen - f0), 72'd5);

    for (int r = 0; r < 3; r++) begin
      int cnt;
      len = $urandom_range(0, 2047);
      cnt = $urandom_range(1, 2);
      da = rand_mac(); sa = rand_mac();
      for (int i = 0; i < cnt; i++) push_frame(len, da, sa);
      start_burst(len, cnt, da, sa);
      finish_burst(1000);
    end

    da = rand_mac(); sa = rand_mac();
    push_frame(300, da, sa);
    start_burst(300, 1, da, sa);
    repeat (10) @(posedge xgmii_tx_clk);
    #1; sys_rst = 1;
    exp_q.delete();
    exp_frames = 0;
`ifdef XGMII_PKTGEN_SEQ_EN
    exp_seq = 0;
`endif
    #1;
    chk("midrst_txd", xgmii_txd, IDLE_W);
    chk("midrst_busy", 72'(busy), 72'd0);
    chk("midrst_tx_frames", 72'(tx_frames), 72'd0);
    @(posedge xgmii_tx_clk); #1; sys_rst = 0;
    push_frame(64, da, sa);
    start_burst(64, 1, da, sa);
    finish_burst(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/xgmii_pktgen.md
Name: xgmii_pktgen

Overview:
- XGMII transmit-side frame generator for the kc705 L2 switch.
- Builds complete Ethernet frames (preamble/SFD, DA, SA, EtherType, pattern payload, FCS) and drives 72-bit {txc,txd} directly onto an XGMII TX lane.
- Used for link bring-up and as a traffic source toward the RX path (xgmii2fifo72 to sfifo) of a peer port; it produces the frames that the RX path consumes.

Parameters:
- IFG_CYCLES, 4'h2: minimum all-idle XGMII cycles after the terminate cycle.
- ETHERTYPE, 16'h88B5: EtherType inserted in bytes 12-13.

Ports:
- xgmii_tx_clk  in  1  156.25 MHz XGMII TX clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a burst when idle.
- stop  in  1  pulse; finishes the current frame, then returns to idle.
- frame_len  in  11  frame bytes DA..FCS inclusive; latched at start.
- frame_cnt  in  16  frames per burst; 0 means continuous.
- dst_mac  in  48  destination MAC; byte [47:40] is sent first.
- src_mac  in  48  source MAC; byte [47:40] is sent first.
- xgmii_txd  out  72  {txc[7:0], txd[63:0]}; lane 0 = txd[7:0] = first on wire.
- busy  out  1  high from start accept until the last IFG cycle ends.
- tx_frames  out  32  count of completed frames; wraps.

Behaviour:
- Reset (asynchronous, active-high), all outputs registered:
  - xgmii_txd = {8'hff, 64'h0707070707070707}; busy=0; tx_frames=0; FSM to IDLE.
  - Takes effect immediately, including mid-frame; no terminate is emitted.
- FSM states: IDLE, PRE, DATA, TERM, IFG.
- IDLE: outputs idle. start=1 latches frame_len, frame_cnt, dst_mac and src_mac, sets busy=1, goes to PRE. start while busy is ignored.
- Length clamp: frame_len<64 uses 64; frame_len>1518 uses 1518.
- PRE: the SFD word {8'h01, 64'hd5555555555555fb} appears on xgmii_txd exactly 2 cycles after the start cycle.
- DATA: ceil(L/8) words with txc=0 for full words.
  - Bytes 0-5 DA, bytes 6-11 SA, bytes 12-13 ETHERTYPE (big-endian).
  - Payload byte at offset k (14 <= k < L-4) = (k-14)[7:0].
  - Last 4 bytes = FCS: ~CRC32 (poly 04C11DB7, reflected, init FFFFFFFF) over bytes 0..L-5, least-significant byte first.
- Terminate:
  - If L%8 != 0: the last data word carries FD in lane L%8, lanes above it carry 07, and txc bits set for lanes >= L%8. Example L=65: txc=8'hfe.
  - If L%8 == 0: TERM emits {8'hff, 64'h07070707070707fd}.
- IFG: IFG_CYCLES cycles of all-idle output.
- After IFG:
  - Increment tx_frames at the end of the terminate cycle.
  - Burst complete (sent == frame_cnt, frame_cnt != 0) or stop seen: go to IDLE and drop busy.
  - Otherwise go to PRE; back-to-back SFD follows immediately after IFG.
- stop: sticky until the burst ends; never truncates a frame. A stop in the same cycle as start is ignored.
- Internal counters:
  - 8-bit word counter (max 190 words).
  - 16-bit frame counter; wraps when continuous, with no effect on operation.

Optional Feature:
- Macro: XGMII_PKTGEN_SEQ_EN.
- Defined: payload bytes 14-17 carry a 32-bit per-frame sequence number, big-endian. It starts at 0 after reset, increments per frame, and persists across bursts. The FCS covers these bytes. Payload bytes from 18 on still follow (k-14)[7:0].
- Undefined: the pure pattern applies for all payload bytes.

Decomposition:
- Package xgmii_pkg holds:
  - XGMII_IDLE=8'h07, XGMII_START=8'hfb, XGMII_TERM=8'hfd, XGMII_ERROR=8'hfe.
  - PREAMBLE_WORD=64'hd5555555555555fb.
  - ETH_MIN_LEN=64, ETH_MAX_LEN=1518.
  - CRC32 polynomial and init constants.
  - FSM state encoding.
- Sub-module crc32_d64: combinational next-CRC over a 64-bit word with an 8-bit byte-enable mask (lanes contiguous from lane 0). Instantiated once in xgmii_pktgen.

Test Plan:
- frame_len=64, frame_cnt=1, dst_mac=ffffffffffff, src_mac=001122334455, start:
  - SFD at start+2 cycles.
  - First data word txd=64'h1100ffffffffffff.
  - 8 data words, then {8'hff, 64'h07070707070707fd}.
  - FCS matches the software CRC; tx_frames=1; busy low after 2 idle cycles.
- frame_len=65: 9th data word has lane0=FCS byte 3, lane1=FD, txc=8'hfe, lanes 2-7 = 07.
- Clamping:
  - frame_len=20 produces 8 data words (64 bytes).
  - frame_len=2000 produces 190 data words, last word txc=8'hc0 (terminate in lane 6).
- frame_cnt=3, IFG_CYCLES=2:
  - Exactly 2 all-idle cycles between each terminate cycle and the next SFD.
  - tx_frames=3; busy drops once; a start pulse mid-burst has no effect.
- frame_cnt=0, stop pulse mid-payload of frame 5: frame 5 completes with a valid FCS, then IDLE; tx_frames=5.
- Reset mid-payload:
  - xgmii_txd={8'hff, 64'h0707070707070707} in the same cycle; busy=0, tx_frames=0.
  - After release, start produces the SFD at +2 cycles.
  - With XGMII_PKTGEN_SEQ_EN, sequence bytes equal 00000000.
